// File: rtl/nbest_regf.sv
// N-best score register: sorted list of (signed score, word index) with in-order readout.
// Latency: insert lands at the next edge; readout beat valid one cycle after rd_start, data muxed straight from registers.
// Backpressure: rd_ready=0 holds the current beat stable; en is dropped while a readout is in progress.
// Optional build macro NBEST_DROP_CNT_EN adds the saturating drop_cnt output.
module nbest_regf #(
  parameter  int SCORE_W = 21,
  parameter  int IDX_W   = 6,
  parameter  int DEPTH   = 4,
  localparam int RANK_W  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic signed [SCORE_W-1:0] fscore,
  input  logic        [IDX_W-1:0]   word_index,
  input  logic                      rd_start,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic signed [SCORE_W-1:0] rd_score,
  output logic        [IDX_W-1:0]   rd_index,
  output logic        [RANK_W-1:0]  rd_rank,
  output logic                      rd_done,
  output logic                      busy,
  output logic        [RANK_W:0]    count,
  output logic signed [SCORE_W-1:0] best_score,
  output logic        [IDX_W-1:0]   best_index
`ifdef NBEST_DROP_CNT_EN
  ,
  output logic        [7:0]         drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DONE
  } state_t;

  localparam logic [RANK_W:0]   ONE_C   = (RANK_W+1)'(1);
  localparam logic [RANK_W:0]   DEPTH_C = (RANK_W+1)'(DEPTH);
  localparam logic [RANK_W-1:0] RANK1_C = RANK_W'(1);

  state_t                    state;
  logic signed [SCORE_W-1:0] sc     [DEPTH];
  logic        [IDX_W-1:0]   ix     [DEPTH];
  logic signed [SCORE_W-1:0] sc_nxt [DEPTH];
  logic        [IDX_W-1:0]   ix_nxt [DEPTH];
  logic        [RANK_W:0]    cnt;
  logic        [RANK_W:0]    pos;
  logic        [IDX_W-1:0]   new_idx;
  logic                      idle;
  logic                      ins_do;
  logic                      start_go;
  logic                      last_beat;

  assign idle    = (state == S_IDLE);
  // Indices arrive 1-based; store 0-based, with 0 clamped to 0.
  assign new_idx = (word_index != '0) ? (word_index - IDX_W'(1)) : '0;

  // Insert position: valid entries that score >= the candidate stay ahead (older wins ties).
  always_comb begin
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((RANK_W+1)'(i) < cnt) && (sc[i] >= fscore)) begin
        pos = pos + ONE_C;
      end
    end
  end

  // Shifted list: keep entries above pos, write candidate at pos, push the rest down one slot.
  always_comb begin
    sc_nxt[0] = (pos == '0) ? fscore  : sc[0];
    ix_nxt[0] = (pos == '0) ? new_idx : ix[0];
    for (int i = 1; i < DEPTH; i++) begin
      if ((RANK_W+1)'(i) < pos) begin
        sc_nxt[i] = sc[i];
        ix_nxt[i] = ix[i];
      end else if ((RANK_W+1)'(i) == pos) begin
        sc_nxt[i] = fscore;
        ix_nxt[i] = new_idx;
      end else begin
        sc_nxt[i] = sc[i-1];
        ix_nxt[i] = ix[i-1];
      end
    end
  end

  // A candidate is taken only while idle and when it beats the tail of a full list.
  assign ins_do    = en && idle && (pos < DEPTH_C);
  // Readout decision sees the list as it will be after a same-cycle insert.
  assign start_go  = (cnt != '0) || ins_do;
  assign last_beat = ({1'b0, rd_rank} == (cnt - ONE_C));

  // List storage and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sc[i] <= '0;
        ix[i] <= '0;
      end
      cnt <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        sc[i] <= '0;
        ix[i] <= '0;
      end
      cnt <= '0;
    end else if (ins_do) begin
      for (int i = 0; i < DEPTH; i++) begin
        sc[i] <= sc_nxt[i];
        ix[i] <= ix_nxt[i];
      end
      if (cnt != DEPTH_C) begin
        cnt <= cnt + ONE_C;
      end
    end
  end

  // Readout FSM with registered rd_valid/rd_done/rd_rank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      rd_rank  <= '0;
    end else if (clear) begin
      state    <= S_IDLE;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      rd_rank  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rd_done <= 1'b0;
          rd_rank <= '0;
          if (rd_start) begin
            if (start_go) begin
              state    <= S_READ;
              rd_valid <= 1'b1;
            end else begin
              state   <= S_DONE;
              rd_done <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (rd_ready) begin
            if (last_beat) begin
              state    <= S_DONE;
              rd_valid <= 1'b0;
              rd_done  <= 1'b1;
            end else begin
              rd_rank <= rd_rank + RANK1_C;
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          rd_done  <= 1'b0;
          rd_valid <= 1'b0;
          rd_rank  <= '0;
        end
        default: begin
          state    <= S_IDLE;
          rd_valid <= 1'b0;
          rd_done  <= 1'b0;
          rd_rank  <= '0;
        end
      endcase
    end
  end

`ifdef NBEST_DROP_CNT_EN
  // Count candidates that were offered but not stored, saturating at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (en && !ins_do && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  assign busy       = !idle;
  assign count      = cnt;
  assign rd_score   = sc[rd_rank];
  assign rd_index   = ix[rd_rank];
  assign best_score = (cnt != '0) ? sc[0] : '0;
  assign best_index = (cnt != '0) ? ix[0] : '0;

endmodule

// File: tb/tb_nbest_regf.sv
// Randomized bench for nbest_regf against a queue-based ranked-list model.
// Checks insert ordering, ties, eviction, readout handshaking, clear and async reset.
// Optional drop counter is exercised when NBEST_DROP_CNT_EN is defined.
module tb_nbest_regf;
  localparam int SW = 21;
  localparam int IW = 6;
  localparam int D  = 4;
  localparam int RW = $clog2(D);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 clear = 1'b0;
  logic                 en = 1'b0;
  logic signed [SW-1:0] fscore = '0;
  logic [IW-1:0]        word_index = '0;
  logic                 rd_start = 1'b0;
  logic                 rd_ready = 1'b0;
  logic                 rd_valid;
  logic signed [SW-1:0] rd_score;
  logic [IW-1:0]        rd_index;
  logic [RW-1:0]        rd_rank;
  logic                 rd_done;
  logic                 busy;
  logic [RW:0]          count;
  logic signed [SW-1:0] best_score;
  logic [IW-1:0]        best_index;
`ifdef NBEST_DROP_CNT_EN
  logic [7:0]           drop_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int mq_s[$];
  int mq_i[$];
  int m_drop = 0;

  nbest_regf #(.SCORE_W(SW), .IDX_W(IW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .fscore(fscore),
    .word_index(word_index), .rd_start(rd_start), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_score(rd_score), .rd_index(rd_index),
    .rd_rank(rd_rank), .rd_done(rd_done), .busy(busy), .count(count),
    .best_score(best_score), .best_index(best_index)
`ifdef NBEST_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_drop_inc();
    if (m_drop < 255) m_drop++;
  endfunction

  function automatic void m_clear();
    mq_s.delete();
    mq_i.delete();
    m_drop = 0;
  endfunction

  // Ranked insert: everything scoring >= f stays ahead; list truncated to D.
  function automatic void m_insert(int f, int w);
    int p = 0;
    foreach (mq_s[k]) if (mq_s[k] >= f) p++;
    if (p < D) begin
      mq_s.insert(p, f);
      mq_i.insert(p, (w > 0) ? w - 1 : 0);
      if (mq_s.size() > D) begin
        void'(mq_s.pop_back());
        void'(mq_i.pop_back());
      end
    end else begin
      m_drop_inc();
    end
  endfunction

  function automatic int rand_score();
    logic signed [SW-1:0] t;
    t = SW'($urandom);
    if ($urandom_range(0, 3) == 0) return int'(t);
    return int'($urandom_range(0, 40)) - 20;
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_count"}, count, mq_s.size());
    check({tag, "_best_score"}, best_score, (mq_s.size() > 0) ? mq_s[0] : 0);
    check({tag, "_best_index"}, best_index, (mq_i.size() > 0) ? mq_i[0] : 0);
`ifdef NBEST_DROP_CNT_EN
    check({tag, "_drop_cnt"}, drop_cnt, m_drop);
`endif
  endtask

  task automatic do_insert(input int f, input int w);
    fscore = SW'(f);
    word_index = IW'(w);
    en = 1'b1;
    step();
    en = 1'b0;
    m_insert(f, w);
    check_status("ins");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_clear();
    check_status("clr");
  endtask

  // mode 0: rd_ready from pat bits (bit n for the n-th READ cycle, 1 beyond 31); mode 1: random.
  task automatic readout(input int mode, input logic [31:0] pat, input bit noise);
    int  k = 0;
    int  n = 0;
    bit  fin = 1'b0;
    bit  rdy;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (rd_done === 1'b1) begin
        check("rd_beats", k, mq_s.size());
        check("rd_valid_at_done", rd_valid, 0);
        fin = 1'b1;
      end else begin
        check("rd_valid", rd_valid, 1);
        if (k < mq_s.size()) begin
          check("rd_rank", rd_rank, k);
          check("rd_score", rd_score, mq_s[k]);
          check("rd_index", rd_index, mq_i[k]);
        end
        if (mode == 0) rdy = (n < 32) ? pat[n] : 1'b1;
        else           rdy = 1'($urandom_range(0, 1));
        n++;
        rd_ready = rdy;
        if (rdy) k++;
        if (noise && $urandom_range(0, 1) == 1) begin
          en = 1'b1;
          fscore = SW'($urandom);
          word_index = IW'($urandom);
          m_drop_inc();
        end else begin
          en = 1'b0;
        end
        step();
      end
    end
    rd_ready = 1'b0;
    en = 1'b0;
    if (!fin) begin
      check("rd_timeout", 0, 1);
    end else begin
      step();
      check("rd_done_pulse", rd_done, 0);
      check("busy_after_done", busy, 0);
    end
    check_status("post_rd");
  endtask

  initial begin
    #12;
    check("rst_count", count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_rd_rank", rd_rank, 0);
    check("rst_busy", busy, 0);
    check("rst_best_score", best_score, 0);
    check("rst_best_index", best_index, 0);
    reset = 1'b0;
    step();

    // Basic ordering.
    do_insert(10, 3);
    do_insert(30, 5);
    do_insert(20, 1);
    do_insert(-5, 9);
    check("plan_count", count, 4);
    check("plan_best_index", best_index, 4);
    readout(0, 32'hFFFF_FFFF, 1'b0);

    // Full-list reject, then eviction of the tail.
    do_insert(-7, 2);
    do_insert(25, 7);
    readout(0, 32'hFFFF_FFFF, 1'b0);

    // Tie goes behind the existing 20; readout with ready 1,0,1,1,1 and en noise.
    do_insert(20, 12);
    readout(0, 32'hFFFF_FFFD, 1'b1);

    // Signed comparison: -5 must rank below +1.
    do_clear();
    do_insert(-5, 1);
    do_insert(1, 2);
    check("signed_best", best_score, 1);

    // Empty readout: no beats, immediate rd_done.
    do_clear();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    check("empty_rd_valid", rd_valid, 0);
    check("empty_rd_done", rd_done, 1);
    step();
    check("empty_rd_done_end", rd_done, 0);
    check("empty_busy_end", busy, 0);

    // Insert and rd_start together: readout sees the new entry.
    fscore = SW'(7);
    word_index = IW'(3);
    en = 1'b1;
    rd_start = 1'b1;
    step();
    en = 1'b0;
    rd_start = 1'b0;
    m_insert(7, 3);
    check("same_cyc_valid", rd_valid, 1);
    check("same_cyc_score", rd_score, 7);
    check("same_cyc_index", rd_index, 2);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("same_cyc_done", rd_done, 1);
    step();

    // Clear in the middle of a readout.
    do_insert(40, 4);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    check("midclr_valid", rd_valid, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_clear();
    check("midclr_valid_drop", rd_valid, 0);
    check("midclr_done", rd_done, 0);
    check("midclr_busy", busy, 0);
    check("midclr_count", count, 0);
    step();
    check("midclr_done_later", rd_done, 0);

    // Random traffic with an asynchronous reset in the middle.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (it == 200) begin
        reset = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_done", rd_done, 0);
        check("arst_rd_rank", rd_rank, 0);
        check("arst_busy", busy, 0);
        check("arst_best_score", best_score, 0);
        check("arst_best_index", best_index, 0);
`ifdef NBEST_DROP_CNT_EN
        check("arst_drop_cnt", drop_cnt, 0);
`endif
        reset = 1'b0;
        m_clear();
        step();
      end else if (r < 70) begin
        do_insert(rand_score(), int'($urandom_range(0, 63)));
      end else if (r < 85) begin
        readout(1, 32'h0, 1'b1);
      end else if (r < 90) begin
        do_clear();
      end else begin
        step();
        check_status("idle");
      end
    end

`ifdef NBEST_DROP_CNT_EN
    do_clear();
    for (int i = 0; i < D; i++) do_insert(100, i + 1);
    for (int i = 0; i < 300; i++) begin
      fscore = SW'(-1000);
      word_index = IW'(1);
      en = 1'b1;
      step();
      m_drop_inc();
    end
    en = 1'b0;
    check("drop_sat", drop_cnt, 255);
    check_status("drop_sat");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
